// File: rtl/zap_cp15_pkg.sv
// Shared CP15 definitions: register numbers, maintenance opcodes, FSM states,
// the decoded request payload and the Rd -> physical register translation.
package zap_cp15_pkg;

  localparam int unsigned PHY_REGS_DEF = 46;
  localparam int unsigned PHY_IDX_W    = $clog2(PHY_REGS_DEF);
  localparam logic [31:0] CP15_ID_DEF  = 32'h4107_9000;
  localparam logic [31:0] CTRL_RESET   = 32'h0000_0078;

  // CP15 primary register numbers (CRn)
  localparam logic [3:0] CRN_ID    = 4'd0;
  localparam logic [3:0] CRN_CTRL  = 4'd1;
  localparam logic [3:0] CRN_TTBR  = 4'd2;
  localparam logic [3:0] CRN_DACR  = 4'd3;
  localparam logic [3:0] CRN_FSR   = 4'd5;
  localparam logic [3:0] CRN_FAR   = 4'd6;
  localparam logic [3:0] CRN_CACHE = 4'd7;
  localparam logic [3:0] CRN_TLB   = 4'd8;

  // CPU modes
  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

  // Physical register file layout for banked registers
  localparam logic [PHY_IDX_W-1:0] PHY_FIQ_R8  = PHY_IDX_W'(16);
  localparam logic [PHY_IDX_W-1:0] PHY_IRQ_R13 = PHY_IDX_W'(23);
  localparam logic [PHY_IDX_W-1:0] PHY_SVC_R13 = PHY_IDX_W'(25);
  localparam logic [PHY_IDX_W-1:0] PHY_UND_R13 = PHY_IDX_W'(27);
  localparam logic [PHY_IDX_W-1:0] PHY_ABT_R13 = PHY_IDX_W'(29);

  typedef enum logic [2:0] {
    MAINT_IC_INV       = 3'd0,
    MAINT_DC_INV       = 3'd1,
    MAINT_DC_CLEAN     = 3'd2,
    MAINT_DC_CLEAN_INV = 3'd3,
    MAINT_TLB_INV      = 3'd4
  } maint_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_RD   = 3'd4,
    ST_MAINT   = 3'd5,
    ST_DONE    = 3'd6
  } cp15_state_t;

  // Fields of the coprocessor word that the responder acts on
  typedef struct packed {
    logic       xfer;  // CP15 MRC/MCR
    logic       load;  // 1 = MRC, 0 = MCR
    logic [3:0] crn;
    logic [3:0] rd;
    logic [3:0] crm;
  } cp_req_t;

  // Map an architectural register number to its physical index for a mode
  function automatic logic [PHY_IDX_W-1:0] translate(input logic [3:0] rd,
                                                     input logic [4:0] mode);
    logic [PHY_IDX_W-1:0] idx;
    logic                 r13_14;
    idx    = PHY_IDX_W'(rd);
    r13_14 = (rd == 4'd13) || (rd == 4'd14);
    case (mode)
      MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14) idx = PHY_FIQ_R8 + PHY_IDX_W'(rd - 4'd8);
      MODE_IRQ: if (r13_14) idx = PHY_IRQ_R13 + PHY_IDX_W'(rd - 4'd13);
      MODE_SVC: if (r13_14) idx = PHY_SVC_R13 + PHY_IDX_W'(rd - 4'd13);
      MODE_UND: if (r13_14) idx = PHY_UND_R13 + PHY_IDX_W'(rd - 4'd13);
      MODE_ABT: if (r13_14) idx = PHY_ABT_R13 + PHY_IDX_W'(rd - 4'd13);
      default:  idx = PHY_IDX_W'(rd);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/zap_cp15_regbank.sv
// CP15 register storage (c1/c2/c3/FSR/FAR) with write decode, fault priority
// and the MRC read mux.
module zap_cp15_regbank
  import zap_cp15_pkg::*;
#(
  parameter logic [31:0] CP15_ID = CP15_ID_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_crn,
  input  logic [31:0] i_wr_data,
  input  logic        i_fault_valid,
  input  logic [7:0]  i_fault_fsr,
  input  logic [31:0] i_fault_far,
  output logic [31:0] o_ctrl,
  output logic [31:0] o_ttbr,
  output logic [31:0] o_dacr,
  output logic [31:0] o_rd_data_c
);

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] ttbr_q, ttbr_d;
  logic [31:0] dacr_q, dacr_d;
  logic [7:0]  fsr_q,  fsr_d;
  logic [31:0] far_q,  far_d;

  // Register writes; a fault capture overrides an MCR to FSR/FAR
  always_comb begin
    ctrl_d = ctrl_q;
    ttbr_d = ttbr_q;
    dacr_d = dacr_q;
    fsr_d  = fsr_q;
    far_d  = far_q;
    if (i_wr_en) begin
      case (i_crn)
        CRN_CTRL: ctrl_d = i_wr_data;
        CRN_TTBR: ttbr_d = i_wr_data;
        CRN_DACR: dacr_d = i_wr_data;
        CRN_FSR:  fsr_d  = i_wr_data[7:0];
        CRN_FAR:  far_d  = i_wr_data;
        default:  ;
      endcase
    end
    if (i_fault_valid) begin
      fsr_d = i_fault_fsr;
      far_d = i_fault_far;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_q <= CTRL_RESET;
      ttbr_q <= '0;
      dacr_q <= '0;
      fsr_q  <= '0;
      far_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      ttbr_q <= ttbr_d;
      dacr_q <= dacr_d;
      fsr_q  <= fsr_d;
      far_q  <= far_d;
    end
  end

  // Read mux for MRC
  always_comb begin
    o_rd_data_c = '0;
    case (i_crn)
      CRN_ID:   o_rd_data_c = CP15_ID;
      CRN_CTRL: o_rd_data_c = ctrl_q;
      CRN_TTBR: o_rd_data_c = ttbr_q;
      CRN_DACR: o_rd_data_c = dacr_q;
      CRN_FSR:  o_rd_data_c = {24'd0, fsr_q};
      CRN_FAR:  o_rd_data_c = far_q;
      default:  o_rd_data_c = '0;
    endcase
  end

  assign o_ctrl = ctrl_q;
  assign o_ttbr = ttbr_q;
  assign o_dacr = dacr_q;

endmodule

// File: rtl/zap_cp15_responder.sv
// CP15 endpoint of the coprocessor dav/done handshake: decodes MRC/MCR,
// moves data through the register-file coprocessor port and issues
// cache/TLB maintenance requests.
module zap_cp15_responder
  import zap_cp15_pkg::*;
#(
  parameter int unsigned PHY_REGS = PHY_REGS_DEF,
  parameter logic [31:0] CP15_ID  = CP15_ID_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_cp_dav,
  input  logic [31:0]                 i_cp_word,
  output logic                        o_cp_done,
  input  logic [4:0]                  i_cpsr_mode,
  output logic                        o_reg_en,
  output logic                        o_reg_wr,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
  output logic [31:0]                 o_reg_wr_data,
  input  logic [31:0]                 i_reg_rd_data,
  output logic [31:0]                 o_ctrl,
  output logic [31:0]                 o_ttbr,
  output logic [31:0]                 o_dacr,
  output logic                        o_maint_req,
  output logic [2:0]                  o_maint_op,
  input  logic                        i_maint_ack,
  input  logic                        i_fault_valid,
  input  logic [7:0]                  i_fault_fsr,
  input  logic [31:0]                 i_fault_far
);

  localparam int unsigned IDX_W = $clog2(PHY_REGS);

  cp15_state_t       state_q, state_d;
  cp_req_t           req_q, req_d;
  logic              done_q, done_d;
  logic              reg_en_q, reg_en_d;
  logic              reg_wr_q, reg_wr_d;
  logic [IDX_W-1:0]  reg_index_q, reg_index_d;
  logic [31:0]       reg_wr_data_q, reg_wr_data_d;
  logic              maint_req_q, maint_req_d;
  maint_op_t         maint_op_q, maint_op_d;
  logic              maint_hit;
  maint_op_t         maint_sel;
  logic              bank_wr_en_c;
  logic [31:0]       bank_rd_data_c;
  logic              unused_word_bits;

  // Condition and opcode fields are resolved upstream
  assign unused_word_bits = ^{i_cp_word[31:28], i_cp_word[23:21], i_cp_word[7:5]};

  // MCR data lands in the bank while sampling the register-file read
  assign bank_wr_en_c = (state_q == ST_RD_WAIT);

  zap_cp15_regbank #(
    .CP15_ID (CP15_ID)
  ) u_regbank (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_wr_en       (bank_wr_en_c),
    .i_crn         (req_q.crn),
    .i_wr_data     (i_reg_rd_data),
    .i_fault_valid (i_fault_valid),
    .i_fault_fsr   (i_fault_fsr),
    .i_fault_far   (i_fault_far),
    .o_ctrl        (o_ctrl),
    .o_ttbr        (o_ttbr),
    .o_dacr        (o_dacr),
    .o_rd_data_c   (bank_rd_data_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    done_d        = 1'b0;
    reg_en_d      = 1'b0;
    reg_wr_d      = 1'b0;
    reg_index_d   = '0;
    reg_wr_data_d = '0;
    maint_req_d   = maint_req_q;
    maint_op_d    = maint_op_q;
    maint_hit     = 1'b0;
    maint_sel     = MAINT_IC_INV;

    case (state_q)
      ST_IDLE: begin
        if (i_cp_dav) begin
          req_d.xfer = (i_cp_word[27:24] == 4'b1110) && i_cp_word[4] &&
                       (i_cp_word[11:8] == 4'd15);
          req_d.load = i_cp_word[20];
          req_d.crn  = i_cp_word[19:16];
          req_d.rd   = i_cp_word[15:12];
          req_d.crm  = i_cp_word[3:0];
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!req_q.xfer) begin
          state_d = ST_DONE;
        end else if (req_q.load) begin
          if (req_q.rd == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            state_d       = ST_WR_RD;
            reg_en_d      = 1'b1;
            reg_wr_d      = 1'b1;
            reg_index_d   = IDX_W'(translate(req_q.rd, i_cpsr_mode));
            reg_wr_data_d = bank_rd_data_c;
          end
        end else begin
          state_d     = ST_RD_REQ;
          reg_en_d    = 1'b1;
          reg_index_d = IDX_W'(translate(req_q.rd, i_cpsr_mode));
        end
      end

      ST_WR_RD:  state_d = ST_DONE;

      ST_RD_REQ: state_d = ST_RD_WAIT;

      ST_RD_WAIT: begin
        if (req_q.crn == CRN_CACHE) begin
          maint_hit = 1'b1;
          case (req_q.crm)
            4'd5:    maint_sel = MAINT_IC_INV;
            4'd6:    maint_sel = MAINT_DC_INV;
            4'd10:   maint_sel = MAINT_DC_CLEAN;
            4'd14:   maint_sel = MAINT_DC_CLEAN_INV;
            default: maint_hit = 1'b0;
          endcase
        end else if (req_q.crn == CRN_TLB) begin
          maint_hit = 1'b1;
          maint_sel = MAINT_TLB_INV;
        end
        if (maint_hit) begin
          state_d     = ST_MAINT;
          maint_req_d = 1'b1;
          maint_op_d  = maint_sel;
        end else begin
          state_d = ST_DONE;
        end
      end

      // Request drops the cycle after ack, done follows one cycle later
      ST_MAINT: begin
        if (!maint_req_q) begin
          state_d = ST_DONE;
        end else if (i_maint_ack) begin
          maint_req_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (!i_cp_dav) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      done_q        <= 1'b0;
      reg_en_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_index_q   <= '0;
      reg_wr_data_q <= '0;
      maint_req_q   <= 1'b0;
      maint_op_q    <= MAINT_IC_INV;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      done_q        <= done_d;
      reg_en_q      <= reg_en_d;
      reg_wr_q      <= reg_wr_d;
      reg_index_q   <= reg_index_d;
      reg_wr_data_q <= reg_wr_data_d;
      maint_req_q   <= maint_req_d;
      maint_op_q    <= maint_op_d;
    end
  end

  assign o_cp_done     = done_q;
  assign o_reg_en      = reg_en_q;
  assign o_reg_wr      = reg_wr_q;
  assign o_reg_index   = reg_index_q;
  assign o_reg_wr_data = reg_wr_data_q;
  assign o_maint_req   = maint_req_q;
  assign o_maint_op    = maint_op_q;

endmodule

// File: tb/tb_zap_cp15_responder.sv
// Directed bench for zap_cp15_responder.
module tb_zap_cp15_responder;

  localparam int unsigned IDX_W = 6;
  localparam logic [4:0]  USR   = 5'h10;
  localparam logic [4:0]  SVC   = 5'h13;

  logic             i_clk;
  logic             i_reset;
  logic             i_cp_dav;
  logic [31:0]      i_cp_word;
  logic             o_cp_done;
  logic [4:0]       i_cpsr_mode;
  logic             o_reg_en;
  logic             o_reg_wr;
  logic [IDX_W-1:0] o_reg_index;
  logic [31:0]      o_reg_wr_data;
  logic [31:0]      i_reg_rd_data;
  logic [31:0]      o_ctrl;
  logic [31:0]      o_ttbr;
  logic [31:0]      o_dacr;
  logic             o_maint_req;
  logic [2:0]       o_maint_op;
  logic             i_maint_ack;
  logic             i_fault_valid;
  logic [7:0]       i_fault_fsr;
  logic [31:0]      i_fault_far;

  int n_tests = 0;
  int n_fail  = 0;

  zap_cp15_responder dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_cp_dav      (i_cp_dav),
    .i_cp_word     (i_cp_word),
    .o_cp_done     (o_cp_done),
    .i_cpsr_mode   (i_cpsr_mode),
    .o_reg_en      (o_reg_en),
    .o_reg_wr      (o_reg_wr),
    .o_reg_index   (o_reg_index),
    .o_reg_wr_data (o_reg_wr_data),
    .i_reg_rd_data (i_reg_rd_data),
    .o_ctrl        (o_ctrl),
    .o_ttbr        (o_ttbr),
    .o_dacr        (o_dacr),
    .o_maint_req   (o_maint_req),
    .o_maint_op    (o_maint_op),
    .i_maint_ack   (i_maint_ack),
    .i_fault_valid (i_fault_valid),
    .i_fault_fsr   (i_fault_fsr),
    .i_fault_far   (i_fault_far)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic do_reset();
    i_reset       = 1'b1;
    i_cp_dav      = 1'b0;
    i_maint_ack   = 1'b0;
    i_fault_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // Issue one request and follow it to done; dav is dropped once done is seen
  task automatic run_req(input logic [31:0] w, output int lat, output logic saw_en,
                         output logic saw_wr, output logic [IDX_W-1:0] idx,
                         output logic [31:0] wd, output logic saw_maint);
    lat = -1; saw_en = 1'b0; saw_wr = 1'b0; idx = '0; wd = '0; saw_maint = 1'b0;
    @(negedge i_clk);
    i_cp_dav  = 1'b1;
    i_cp_word = w;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (o_reg_en) begin
        saw_en = 1'b1; saw_wr = o_reg_wr; idx = o_reg_index; wd = o_reg_wr_data;
      end
      if (o_maint_req) saw_maint = 1'b1;
      if (o_cp_done) begin lat = c; break; end
    end
    i_cp_dav = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    n_tests++; if (o_cp_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_cp_done); end
    n_tests++; if (o_reg_en !== 1'b0) begin n_fail++; $display("FAIL reset_reg_en: got %b expected 0", o_reg_en); end
    n_tests++; if (o_maint_req !== 1'b0) begin n_fail++; $display("FAIL reset_maint_req: got %b expected 0", o_maint_req); end
    n_tests++; if (o_ctrl !== 32'h0000_0078) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00000078", o_ctrl); end
    n_tests++; if (o_ttbr !== 32'h0) begin n_fail++; $display("FAIL reset_ttbr: got %h expected 0", o_ttbr); end
    n_tests++; if (o_dacr !== 32'h0) begin n_fail++; $display("FAIL reset_dacr: got %h expected 0", o_dacr); end
    n_tests++; if (o_reg_wr_data !== 32'h0 || o_reg_index !== '0 || o_maint_op !== 3'd0) begin
      n_fail++; $display("FAIL reset_misc: got wd=%h idx=%0d op=%0d expected 0", o_reg_wr_data, o_reg_index, o_maint_op);
    end
  endtask

  task automatic test_mrc_id();
    int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    i_cpsr_mode = USR;
    run_req(32'hEE10_3F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL mrc_latency: got %0d expected 3", lat); end
    n_tests++; if (en !== 1'b1 || wr !== 1'b1) begin n_fail++; $display("FAIL mrc_port: got en=%b wr=%b expected 1 1", en, wr); end
    n_tests++; if (idx !== 6'd3) begin n_fail++; $display("FAIL mrc_index: got %0d expected 3", idx); end
    n_tests++; if (wd !== 32'h4107_9000) begin n_fail++; $display("FAIL mrc_id_data: got %h expected 41079000", wd); end
    n_tests++; if (o_cp_done !== 1'b0) begin n_fail++; $display("FAIL mrc_done_release: got %b expected 0", o_cp_done); end
  endtask

  task automatic test_mcr_ttbr();
    int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    i_cpsr_mode   = SVC;
    i_reg_rd_data = 32'hABCD_0000;
    run_req(32'hEE02_1F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL mcr_latency: got %0d expected 4", lat); end
    n_tests++; if (en !== 1'b1 || wr !== 1'b0) begin n_fail++; $display("FAIL mcr_port: got en=%b wr=%b expected 1 0", en, wr); end
    n_tests++; if (idx !== 6'd1) begin n_fail++; $display("FAIL mcr_index: got %0d expected 1", idx); end
    n_tests++; if (o_ttbr !== 32'hABCD_0000) begin n_fail++; $display("FAIL mcr_ttbr: got %h expected abcd0000", o_ttbr); end
    // R13 in SVC is banked
    i_reg_rd_data = 32'h5555_5555;
    run_req(32'hEE03_DF10, lat, en, wr, idx, wd, mt);
    n_tests++; if (idx !== 6'd25) begin n_fail++; $display("FAIL mcr_svc_r13_index: got %0d expected 25", idx); end
    n_tests++; if (o_dacr !== 32'h5555_5555) begin n_fail++; $display("FAIL mcr_dacr: got %h expected 55555555", o_dacr); end
    // Read TTBR back into SVC R14
    run_req(32'hEE12_EF10, lat, en, wr, idx, wd, mt);
    n_tests++; if (idx !== 6'd26 || wr !== 1'b1 || wd !== 32'hABCD_0000) begin
      n_fail++; $display("FAIL mrc_ttbr_readback: got idx=%0d wr=%b data=%h expected 26 1 abcd0000", idx, wr, wd);
    end
  endtask

  task automatic test_maint();
    int got; int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    i_cpsr_mode = USR;
    @(negedge i_clk);
    i_cp_dav = 1'b1; i_cp_word = 32'hEE07_2F16;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_maint_req) begin got = c; break; end
    end
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL maint_req_start: got cycle %0d expected 4", got); end
    n_tests++; if (o_maint_op !== 3'd1) begin n_fail++; $display("FAIL maint_op_dcinv: got %0d expected 1", o_maint_op); end
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      n_tests++;
      if (o_maint_req !== 1'b1 || o_maint_op !== 3'd1 || o_cp_done !== 1'b0) begin
        n_fail++; $display("FAIL maint_hold: got req=%b op=%0d done=%b expected 1 1 0", o_maint_req, o_maint_op, o_cp_done);
      end
    end
    i_maint_ack = 1'b1;
    @(negedge i_clk);
    i_maint_ack = 1'b0;
    n_tests++; if (o_maint_req !== 1'b0 || o_cp_done !== 1'b0) begin
      n_fail++; $display("FAIL maint_ack_plus1: got req=%b done=%b expected 0 0", o_maint_req, o_cp_done);
    end
    @(negedge i_clk);
    n_tests++; if (o_cp_done !== 1'b1) begin n_fail++; $display("FAIL maint_ack_plus2_done: got %b expected 1", o_cp_done); end
    i_cp_dav = 1'b0;
    @(negedge i_clk);
    n_tests++; if (o_cp_done !== 1'b0) begin n_fail++; $display("FAIL maint_done_release: got %b expected 0", o_cp_done); end

    // c8: TLB invalidate regardless of CRm
    @(negedge i_clk);
    i_cp_dav = 1'b1; i_cp_word = 32'hEE08_0F17;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_maint_req) begin got = c; break; end
    end
    n_tests++; if (o_maint_op !== 3'd4 || got !== 4) begin
      n_fail++; $display("FAIL maint_tlb: got op=%0d cycle=%0d expected 4 4", o_maint_op, got);
    end
    i_maint_ack = 1'b1;
    @(negedge i_clk);
    i_maint_ack = 1'b0;
    got = -1;
    for (int c = 1; c <= 10; c++) begin
      if (o_cp_done) begin got = c; break; end
      @(negedge i_clk);
    end
    n_tests++; if (got !== 2) begin n_fail++; $display("FAIL maint_tlb_done: got %0d expected 2", got); end
    i_cp_dav = 1'b0;
    @(negedge i_clk);

    // c7 with an unsupported CRm is a plain write
    run_req(32'hEE07_2F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 4 || mt !== 1'b0) begin
      n_fail++; $display("FAIL c7_bad_crm: got lat=%0d maint=%b expected 4 0", lat, mt);
    end
  endtask

  task automatic test_stall();
    int got; logic bad;
    i_cpsr_mode = USR;
    @(negedge i_clk);
    i_cp_dav = 1'b1; i_cp_word = 32'hEE10_3F10;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_cp_done) begin got = c; break; end
    end
    n_tests++; if (got !== 3) begin n_fail++; $display("FAIL stall_first_done: got %0d expected 3", got); end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      n_tests++;
      if (o_cp_done !== 1'b1 || o_reg_en !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got done=%b reg_en=%b expected 1 0", o_cp_done, o_reg_en);
      end
    end
    i_cp_dav = 1'b0;
    @(negedge i_clk);
    n_tests++; if (o_cp_done !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", o_cp_done); end
    @(negedge i_clk);
    n_tests++; if (o_cp_done !== 1'b0 || o_reg_en !== 1'b0) begin
      n_fail++; $display("FAIL stall_idle: got done=%b reg_en=%b expected 0 0", o_cp_done, o_reg_en);
    end
  endtask

  task automatic test_noop();
    int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    run_req(32'hEE02_1E10, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 2 || en !== 1'b0) begin n_fail++; $display("FAIL noop_cp14: got lat=%0d en=%b expected 2 0", lat, en); end
    run_req(32'hEE02_1F00, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 2 || en !== 1'b0) begin n_fail++; $display("FAIL noop_cdp: got lat=%0d en=%b expected 2 0", lat, en); end
    run_req(32'hEE10_FF10, lat, en, wr, idx, wd, mt);
    n_tests++; if (lat !== 2 || en !== 1'b0) begin n_fail++; $display("FAIL noop_mrc_r15: got lat=%0d en=%b expected 2 0", lat, en); end
  endtask

  task automatic test_dav_drop();
    int first; int cnt;
    i_cpsr_mode   = USR;
    i_reg_rd_data = 32'h0000_1234;
    @(negedge i_clk);
    i_cp_dav = 1'b1; i_cp_word = 32'hEE01_0F10;
    @(negedge i_clk);
    i_cp_dav = 1'b0;
    first = -1; cnt = 0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge i_clk);
      if (o_cp_done) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    n_tests++; if (first !== 4 || cnt !== 1) begin
      n_fail++; $display("FAIL dav_drop_pulse: got first=%0d count=%0d expected 4 1", first, cnt);
    end
    n_tests++; if (o_ctrl !== 32'h0000_1234) begin n_fail++; $display("FAIL dav_drop_ctrl: got %h expected 00001234", o_ctrl); end
  endtask

  task automatic test_fault();
    int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    i_cpsr_mode   = USR;
    i_reg_rd_data = 32'hDEAD_BEEF;
    run_req(32'hEE06_4F10, lat, en, wr, idx, wd, mt);
    run_req(32'hEE16_7F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (wd !== 32'hDEAD_BEEF || idx !== 6'd7) begin
      n_fail++; $display("FAIL far_write: got data=%h idx=%0d expected deadbeef 7", wd, idx);
    end
    i_reg_rd_data = 32'h0000_0001;
    i_fault_fsr   = 8'h5A;
    i_fault_far   = 32'h0000_0002;
    i_fault_valid = 1'b1;
    run_req(32'hEE06_4F10, lat, en, wr, idx, wd, mt);
    i_fault_valid = 1'b0;
    run_req(32'hEE16_7F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (wd !== 32'h0000_0002) begin n_fail++; $display("FAIL fault_far_wins: got %h expected 00000002", wd); end
    run_req(32'hEE15_8F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (wd !== 32'h0000_005A) begin n_fail++; $display("FAIL fault_fsr: got %h expected 0000005a", wd); end
  endtask

  task automatic test_reset_maint();
    int got; int lat; logic en, wr, mt; logic [IDX_W-1:0] idx; logic [31:0] wd;
    i_cpsr_mode   = USR;
    i_reg_rd_data = 32'h0000_00FF;
    run_req(32'hEE01_0F10, lat, en, wr, idx, wd, mt);
    n_tests++; if (o_ctrl !== 32'h0000_00FF) begin n_fail++; $display("FAIL ctrl_write: got %h expected 000000ff", o_ctrl); end
    @(negedge i_clk);
    i_cp_dav = 1'b1; i_cp_word = 32'hEE07_2F1E;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_maint_req) begin got = c; break; end
    end
    n_tests++; if (got !== 4 || o_maint_op !== 3'd3) begin
      n_fail++; $display("FAIL maint_clean_inv: got cycle=%0d op=%0d expected 4 3", got, o_maint_op);
    end
    i_reset  = 1'b1;
    i_cp_dav = 1'b0;
    @(negedge i_clk);
    n_tests++; if (o_maint_req !== 1'b0 || o_cp_done !== 1'b0 || o_maint_op !== 3'd0) begin
      n_fail++; $display("FAIL reset_in_maint: got req=%b done=%b op=%0d expected 0 0 0", o_maint_req, o_cp_done, o_maint_op);
    end
    n_tests++; if (o_ctrl !== 32'h0000_0078) begin n_fail++; $display("FAIL reset_in_maint_ctrl: got %h expected 00000078", o_ctrl); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_cp_dav      = 1'b0;
    i_cp_word     = '0;
    i_cpsr_mode   = USR;
    i_reg_rd_data = '0;
    i_maint_ack   = 1'b0;
    i_fault_valid = 1'b0;
    i_fault_fsr   = '0;
    i_fault_far   = '0;
    test_reset();
    test_mrc_id();
    test_mcr_ttbr();
    test_maint();
    test_stall();
    test_noop();
    test_dav_drop();
    test_fault();
    test_reset_maint();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zap_cp15_responder.md
Name: zap_cp15_responder

Overview:
- CP15 endpoint of the ZAP coprocessor handshake; the requester is the predecode stage, which holds a 32-bit coprocessor word with a dav flag until it sees done.
- Decodes MRC/MCR to CP15 and moves data between the CPU physical register file and the CP15 registers. The register file is accessed through its coprocessor port.
- Issues cache/TLB maintenance requests to the memory subsystem and captures MMU faults.
- Sits beside the core; the only coupling to the pipeline is the dav/done handshake.

Parameters:
- PHY_REGS, 46, physical register count; index width is $clog2(PHY_REGS).
- CP15_ID, 32'h4107_9000, read-only value returned for c0.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous active-high reset
- i_cp_dav  in  1  request valid; held high until done is observed
- i_cp_word  in  32  instruction word; stable while i_cp_dav is high
- o_cp_done  out  1  request complete
- i_cpsr_mode  in  5  current CPU mode, used for Rd translation
- o_reg_en  out  1  register-file port enable
- o_reg_wr  out  1  1 = write, 0 = read
- o_reg_index  out  $clog2(PHY_REGS)  physical register index
- o_reg_wr_data  out  32  write data
- i_reg_rd_data  in  32  read data, valid one cycle after a read enable
- o_ctrl  out  32  c1 control
- o_ttbr  out  32  c2 translation table base
- o_dacr  out  32  c3 domain access control
- o_maint_req  out  1  maintenance request level
- o_maint_op  out  3  maintenance op: 0 icache inval, 1 dcache inval, 2 dcache clean, 3 clean+inval, 4 TLB inval
- i_maint_ack  in  1  maintenance complete (1-cycle pulse)
- i_fault_valid  in  1  MMU fault capture strobe
- i_fault_fsr  in  8  fault status
- i_fault_far  in  32  fault address

Behaviour:
- Reset (also mid-operation):
  - State IDLE; all outputs 0 except o_ctrl = 32'h0000_0078.
  - o_ttbr, o_dacr, FSR, FAR = 0.
  - Any request in flight is dropped; the requester is also reset.
- Field decode:
  - cp#=word[11:8], L=word[20], CRn=word[19:16], Rd=word[15:12].
  - MRC/MCR are identified by word[27:24]=4'b1110 and word[4]=1.
- States: IDLE, DECODE, RD_REQ, RD_WAIT, WR_RD, MAINT, DONE.
- IDLE: on i_cp_dav=1, latch the word and go to DECODE.
- DECODE routes the request (one cycle):
  - cp# != 15, or not MRC/MCR (LDC/STC/CDP) -> DONE. Treated as a no-op.
  - MRC with Rd=15 -> DONE as a no-op. Flag writes are unsupported.
  - MRC -> WR_RD.
  - MCR -> RD_REQ.
- WR_RD (one cycle):
  - Drive o_reg_en=1, o_reg_wr=1, o_reg_index=translate(Rd, i_cpsr_mode).
  - o_reg_wr_data by CRn: c0=CP15_ID, c1..c3 = register values, c5={24'd0,FSR}, c6=FAR, any other = 0.
  - Then -> DONE.
- RD_REQ: drive o_reg_en=1, o_reg_wr=0, same index; -> RD_WAIT.
- RD_WAIT: sample i_reg_rd_data and write it by CRn:
  - c1/c2/c3: update the register.
  - c5/c6: update FSR/FAR.
  - c7 or c8: select the maintenance op and go to MAINT instead of DONE.
    - Op 0 for CRm=5, 1 for CRm=6, 2 for CRm=10, 3 for CRm=14.
    - c8 (any CRm) gives op 4.
    - Any other c7 CRm -> DONE.
  - c0 and undefined CRn: write ignored, -> DONE.
- MAINT:
  - Hold o_maint_req=1 and o_maint_op stable.
  - On i_maint_ack, drop the request next cycle and go to DONE.
  - There is no timeout.
- DONE:
  - o_cp_done=1, held until i_cp_dav is sampled 0, then -> IDLE.
  - This absorbs requester stalls.
  - A new dav is never accepted in the same cycle that done is released.
- Faults:
  - i_fault_valid captures FSR/FAR in any state.
  - If it coincides with an MCR write to c5/c6, the fault wins.
- Timing:
  - o_ctrl/o_ttbr/o_dacr update the cycle after RD_WAIT.
  - MCR latency, dav to done (non-maint): 4 cycles.
  - MRC latency: 3 cycles.
- Protocol violations: if i_cp_dav drops before DONE, the operation still completes. Done is pulsed for one cycle, then the block returns to IDLE.

Decomposition:
- Shared header (zap_localparams.vh / zap_functions.vh):
  - CRn constants, maintenance opcode constants, state encodings.
  - The translate(Rd, mode) function, reused from the core.
- One natural sub-module: zap_cp15_regbank. It holds c1/c2/c3/FSR/FAR, the write decode and fault-priority logic, and the read mux; the FSM stays in the top.

Test Plan:
- MCR p15,0,R1,c2,c0 in SVC mode, R1=32'hABCD_0000 -> read index = translate(1, SVC); o_ttbr=32'hABCD_0000; done 4 cycles after dav.
- MRC p15,0,R3,c0,c0 in USR... (after reset) -> write index = translate(3, mode), data 32'h4107_9000, done after 3 cycles.
- MCR c7,c6 -> o_maint_req=1, op=1 held for 10 cycles until ack; done exactly 2 cycles after ack.
- dav held high for 5 cycles after done (requester stall) -> done stays high, no re-execution, IDLE after dav falls.
- cp#=14 word or CDP -> no register-port activity; done within 2 cycles.
- Reset asserted in MAINT -> o_maint_req=0, o_cp_done=0, o_ctrl=32'h78 the next cycle.
- i_fault_valid together with MCR to c6 with data 32'h1 and fault address 32'h2 -> FAR=32'h2.
